// File: rtl/br_param.sv
// Parameterised 2-read/1-write register file with optional hardwired-zero r0,
// optional write-to-read forwarding and a one-register-per-cycle clear sweep.
module br_param #(
   parameter int WIDTH   = 32,
   parameter int AW      = 5,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    a1,
   input  logic [AW-1:0]    a2,
   input  logic [AW-1:0]    a3,
   input  logic [WIDTH-1:0] wd3,
   input  logic             we3,
   input  logic             clr_req,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic             busy,
   output logic             state_dbg,
   output logic [AW-1:0]    cnt_dbg
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t           state;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] regs [DEPTH];
   logic             a3_zero;
   logic             wr_ok;

   // A write is accepted only outside a sweep and never to a hardwired-zero r0.
   assign a3_zero = (ZERO_R0 != 0) && (a3 == '0);
   assign wr_ok   = we3 && !busy && !a3_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               // A write on the clr_req edge still lands; the sweep zeroes it later.
               if (wr_ok) begin
                  regs[a3] <= wd3;
               end
               if (clr_req) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               regs[cnt] <= '0;
               if (cnt == '1) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Forwarding uses wr_ok, so it is suppressed during a sweep and for r0.
   always_comb begin
      rd1 = regs[a1];
      if ((ZERO_R0 != 0) && (a1 == '0)) begin
         rd1 = '0;
      end else if ((BYPASS != 0) && wr_ok && (a3 == a1)) begin
         rd1 = wd3;
      end
   end

   always_comb begin
      rd2 = regs[a2];
      if ((ZERO_R0 != 0) && (a2 == '0)) begin
         rd2 = '0;
      end else if ((BYPASS != 0) && wr_ok && (a3 == a2)) begin
         rd2 = wd3;
      end
   end

   assign state_dbg = (state == CLEAR);
   assign cnt_dbg   = cnt;

endmodule

// File: doc/br_param.md
BR_PARAM -- requirements
Module: br_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter AW, default 5, address width; DEPTH = 2**AW registers.
REQ-003 SHALL have parameter ZERO_R0, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding on rd1/rd2.
REQ-005 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port a1, input, AW, read address, port 1.
REQ-008 SHALL have port a2, input, AW, read address, port 2.
REQ-009 SHALL have port a3, input, AW, write address.
REQ-010 SHALL have port wd3, input, WIDTH, write data.
REQ-011 SHALL have port we3, input, 1, write enable.
REQ-012 SHALL have port clr_req, input, 1, request sequential clear of all registers.
REQ-013 SHALL have port rd1, output, WIDTH, read data, port 1.
REQ-014 SHALL have port rd2, output, WIDTH, read data, port 2.
REQ-015 SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-016 SHALL read combinationally: rd1 = reg[a1], rd2 = reg[a2], zero latency.
REQ-017 SHALL write wd3 into reg[a3] on the rising clk edge when we3=1 and busy=0.
REQ-018 SHALL ignore we3 while busy=1; no register other than the sweep target changes.
REQ-019 With ZERO_R0=1: writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0, bypass included.
REQ-020 With BYPASS=1: if we3=1, busy=0, a3==a1, and address not hardwired zero, rd1 SHALL equal wd3 in the same cycle; the same rule SHALL apply to rd2 with a2.
REQ-021 With BYPASS=0: rd1/rd2 SHALL return the stored value and show the new value only after the write edge.
REQ-022 SHALL implement FSM states IDLE and CLEAR with a sweep counter cnt of AW bits.
REQ-023 IDLE -> CLEAR SHALL occur on an edge with clr_req=1; cnt SHALL load 0 and busy SHALL rise after that edge.
REQ-024 In CLEAR, each edge SHALL write 0 to reg[cnt] and then increment cnt.
REQ-025 CLEAR -> IDLE SHALL occur on the edge that clears reg[DEPTH-1]; busy SHALL be high for exactly DEPTH cycles.
REQ-026 clr_req SHALL be ignored while in CLEAR; there SHALL be no restart and no queued request.
REQ-027 clr_req=1 together with we3=1 in IDLE: the write SHALL commit on that edge and the sweep SHALL then overwrite it with 0.
REQ-028 During CLEAR, reads SHALL return current contents: already-swept registers read 0, others keep their old values, and no bypass applies.
REQ-029 cnt SHALL wrap at DEPTH-1 only by returning to IDLE; no out-of-range index SHALL be produced.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, set all registers to 0, state to IDLE, cnt to 0 and busy to 0; rd1/rd2 SHALL then read 0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep, leave all registers 0, and leave busy=0.
REQ-032 On rst_n deassertion, the first edge with rst_n=1 SHALL be the first functional edge.

Verification
REQ-033 Reset, then a1=0, a2=5 -> rd1=0, rd2=0; busy=0.
REQ-034 we3=1, a3=4, wd3=4; next edge we3=1, a3=5, wd3=8; then we3=0, a1=4, a2=5 -> rd1=4, rd2=8.
REQ-035 BYPASS=1: we3=1, a3=7, wd3=0xDEADBEEF, a1=7 before the edge -> rd1=0xDEADBEEF in the same cycle; BYPASS=0 -> rd1 shows the old value until after the edge.
REQ-036 ZERO_R0=1: we3=1, a3=0, wd3=0xFFFFFFFF, a1=0 -> rd1=0 before and after the edge.
REQ-037 Regs 4/5 = 4/8; pulse clr_req -> busy high for 32 cycles; a write with we3=1 during the sweep is ignored; after the sweep, rd1(a1=4)=0 and rd2(a2=5)=0.
REQ-038 Start a sweep, assert rst_n=0 at cycle 10 -> busy=0 immediately, all registers read 0, and clr_req after release starts a fresh 32-cycle sweep.
